// File: rtl/piramide_seq_pkg.sv
// -----------------------------------------------------------------------------
// piramide_seq_pkg
//   Shared types and constants for the piramide sequencer.
//   - PYR_W            : width of the piramide max/outputM_ datapath
//   - DEFAULT_TIMEOUT  : default per-segment cycle budget (rise plus fall)
//   - seq_state_t      : sequencer FSM states
// -----------------------------------------------------------------------------
package piramide_seq_pkg;

    localparam int unsigned PYR_W           = 4;
    localparam int unsigned DEFAULT_TIMEOUT = 64;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RUN_UP   = 3'd2,
        RUN_DOWN = 3'd3,
        NEXT     = 3'd4,
        DONE     = 3'd5
    } seq_state_t;

endpackage : piramide_seq_pkg

// File: rtl/piramide_cfg_table.sv
// -----------------------------------------------------------------------------
// piramide_cfg_table
//   DEPTH x PYR_W peak-value register file.
//   Ports:
//     clk      in  : clock, rising edge
//     rst      in  : asynchronous active-low reset, clears every entry to zero
//     we       in  : write strobe
//     waddr    in  : write address
//     wdata    in  : write data (visible on the read port the next cycle)
//     raddr    in  : read address
//     rdata    out : combinational read data for raddr
// -----------------------------------------------------------------------------
module piramide_cfg_table
    import piramide_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [PYR_W-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [PYR_W-1:0]         rdata
);

    logic [PYR_W-1:0] mem_q [DEPTH];
    logic [PYR_W-1:0] mem_d [DEPTH];

    // NOTE: every variable assigned in always_comb gets a default first,
    // otherwise the untaken branches infer latches.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // NOTE: this table is tiny and a zero entry means "skip", so it is reset
    // like ordinary flops; large RAM macros would normally be left unreset.
    // NOTE: sequential state uses non-blocking assignments only, so all flops
    // update together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : piramide_cfg_table

// File: rtl/piramide_seq.sv
// -----------------------------------------------------------------------------
// piramide_seq
//   Sequencer for one piramide up/down counter. Walks entries 0..len-1 of a
//   peak table; for each entry it resets the piramide, loads the peak onto
//   pyr_max and waits for one full rise and fall of pyr_out.
//   Ports:
//     clk          in  : clock, rising edge
//     rst          in  : asynchronous active-low reset
//     cfg_we/addr/data  in  : peak table write port (accepted in every state)
//     len          in  : entries to run, sampled with start, clamped to DEPTH
//     start        in  : begin a sequence (ignored while busy)
//     abort        in  : return to IDLE immediately (ignored in IDLE)
//     pyr_rst      out : active-high reset to the piramide
//     pyr_max      out : peak value to the piramide
//     pyr_out      in  : piramide outputM_
//     busy         out : sequence in progress
//     done         out : one-cycle pulse at the end of a sequence
//     seg_idx      out : index of the entry currently running
//     timeout_err  out : sticky segment-timeout flag
//   All outputs are registered.
// -----------------------------------------------------------------------------
module piramide_seq
    import piramide_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [PYR_W-1:0]         cfg_data,
    input  logic [$clog2(DEPTH):0]   len,
    input  logic                     start,
    input  logic                     abort,
    output logic                     pyr_rst,
    output logic [PYR_W-1:0]         pyr_max,
    input  logic [PYR_W-1:0]         pyr_out,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] seg_idx,
    output logic                     timeout_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned LEN_W = IDX_W + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT);

    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    seq_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               pyr_rst_q, pyr_rst_d;
    logic [PYR_W-1:0]   pyr_max_q, pyr_max_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               timeout_err_q, timeout_err_d;

    logic [PYR_W-1:0]   tbl_rdata;
    logic [LEN_W-1:0]   len_clamped;
    logic               last_seg;
    logic               start_empty;

    piramide_cfg_table #(
        .DEPTH (DEPTH)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (idx_q),
        .rdata (tbl_rdata)
    );

    assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;

    // The entry being finished is the last one when idx+1 reaches the latched
    // length; compared one bit wider so len == DEPTH is reachable.
    assign last_seg = (({1'b0, idx_q} + LEN_W'(1)) == len_q);

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        len_d         = len_q;
        timer_d       = timer_q;
        pyr_max_d     = pyr_max_q;
        timeout_err_d = timeout_err_q;
        start_empty   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_clamped != '0) begin
                        len_d         = len_clamped;
                        idx_d         = '0;
                        timeout_err_d = 1'b0;
                        state_d       = LOAD;
                    end else begin
                        start_empty = 1'b1;
                    end
                end
            end

            LOAD: begin
                // pyr_max is captured here and held for the whole segment, so
                // a table write to the running entry cannot disturb it.
                pyr_max_d = tbl_rdata;
                timer_d   = '0;
                state_d   = (tbl_rdata == '0) ? NEXT : RUN_UP;
            end

            RUN_UP: begin
                timer_d = timer_q + TMR_W'(1);
                if (pyr_out == pyr_max_q) begin
                    state_d = RUN_DOWN;
                end else if (timer_q == TMR_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                end
            end

            RUN_DOWN: begin
                // The timer keeps running from RUN_UP: the budget covers the
                // whole segment, not each half.
                timer_d = timer_q + TMR_W'(1);
                if (pyr_out == '0) begin
                    state_d = NEXT;
                end else if (timer_q == TMR_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                end
            end

            NEXT: begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = last_seg ? DONE : LOAD;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // abort outranks every transition above but leaves the error flag and
        // the loaded peak untouched.
        if (abort && (state_q != IDLE)) begin
            state_d       = IDLE;
            pyr_max_d     = pyr_max_q;
            timeout_err_d = timeout_err_q;
        end

        // Outputs are registered, so they are derived from the next state.
        pyr_rst_d = !((state_d == RUN_UP) || (state_d == RUN_DOWN));
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE) || start_empty;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            len_q         <= '0;
            timer_q       <= '0;
            pyr_rst_q     <= 1'b1;
            pyr_max_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            timer_q       <= timer_d;
            pyr_rst_q     <= pyr_rst_d;
            pyr_max_q     <= pyr_max_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign pyr_rst     = pyr_rst_q;
    assign pyr_max     = pyr_max_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign seg_idx     = idx_q;
    assign timeout_err = timeout_err_q;

endmodule : piramide_seq

// File: tb/tb_piramide_seq.sv
// -----------------------------------------------------------------------------
// tb_piramide_seq
//   Directed bench for piramide_seq connected to an ideal piramide model
//   (+1 per cycle up to max, then -1 per cycle down to 0, cleared by pyr_rst).
//   hold_zero pins the model output at 0 to force a segment timeout.
// -----------------------------------------------------------------------------
module tb_piramide_seq;
    import piramide_seq_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [3:0] cfg_data;
    logic [3:0] len;
    logic       start;
    logic       abort;
    logic       pyr_rst;
    logic [3:0] pyr_max;
    logic [3:0] pyr_out = 4'd0;
    logic       busy;
    logic       done;
    logic [2:0] seg_idx;
    logic       timeout_err;

    logic       hold_zero = 1'b0;
    logic       pyr_up    = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piramide_seq #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .len         (len),
        .start       (start),
        .abort       (abort),
        .pyr_rst     (pyr_rst),
        .pyr_max     (pyr_max),
        .pyr_out     (pyr_out),
        .busy        (busy),
        .done        (done),
        .seg_idx     (seg_idx),
        .timeout_err (timeout_err)
    );

    // Ideal piramide.
    always @(posedge clk) begin
        if (pyr_rst || hold_zero) begin
            pyr_out <= 4'd0;
            pyr_up  <= 1'b1;
        end else if (pyr_up) begin
            if (pyr_out == pyr_max) begin
                pyr_up  <= 1'b0;
                pyr_out <= pyr_out - 4'd1;
            end else begin
                pyr_out <= pyr_out + 4'd1;
            end
        end else if (pyr_out != 4'd0) begin
            pyr_out <= pyr_out - 4'd1;
        end
    end

    // Passive monitor: cumulative done pulses, RUN cycles, and the peak/index
    // seen at the start of every running segment.
    logic       mon_prev_rst = 1'b1;
    int         done_cnt = 0;
    int         run_cnt  = 0;
    logic [3:0] seg_peak [$];
    logic [2:0] seg_num  [$];

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (pyr_rst === 1'b0) begin
            run_cnt++;
            if (mon_prev_rst) begin
                seg_peak.push_back(pyr_max);
                seg_num.push_back(seg_idx);
            end
        end
        mon_prev_rst = pyr_rst;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input int val);
        cfg_we   = 1'b1;
        cfg_addr = 3'(addr);
        cfg_data = 4'(val);
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        len   = 4'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while (done !== 1'b1 && i < budget) begin
            tick();
            i++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    int seg0, done0, run0;
    int i;

    initial begin
        // ---------------- reset with random inputs ----------------
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cfg_we   = 1'($urandom);
            cfg_addr = 3'($urandom);
            cfg_data = 4'($urandom);
            len      = 4'($urandom);
            start    = 1'($urandom);
            abort    = 1'($urandom);
            tick();
        end
        check("rst_pyr_rst", 32'(pyr_rst), 32'd1);
        check("rst_pyr_max", 32'(pyr_max), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_seg_idx", 32'(seg_idx), 32'd0);
        cfg_we = 1'b0; start = 1'b0; abort = 1'b0; len = 4'd0;
        cfg_addr = 3'd0; cfg_data = 4'd0;
        tick();
        rst = 1'b1;
        tick();

        // ---------------- three-entry run {3,5,2} ----------------
        write_entry(0, 3);
        write_entry(1, 5);
        write_entry(2, 2);
        seg0 = seg_peak.size(); done0 = done_cnt; run0 = run_cnt;
        pulse_start(3);
        check("run3_busy_t1", 32'(busy), 32'd1);
        check("run3_pyr_rst_load", 32'(pyr_rst), 32'd1);
        tick();
        check("run3_pyr_rst_t2", 32'(pyr_rst), 32'd0);
        check("run3_pyr_max_t2", 32'(pyr_max), 32'd3);
        check("run3_seg_idx_t2", 32'(seg_idx), 32'd0);
        wait_done("run3", 100);
        check("run3_busy_in_done", 32'(busy), 32'd1);
        check("run3_timeout_err", 32'(timeout_err), 32'd0);
        tick();
        check("run3_busy_after", 32'(busy), 32'd0);
        check("run3_done_single", 32'(done), 32'd0);
        check("run3_segments", 32'(seg_peak.size() - seg0), 32'd3);
        check("run3_peak0", 32'(seg_peak[seg0]), 32'd3);
        check("run3_peak1", 32'(seg_peak[seg0 + 1]), 32'd5);
        check("run3_peak2", 32'(seg_peak[seg0 + 2]), 32'd2);
        check("run3_idx0", 32'(seg_num[seg0]), 32'd0);
        check("run3_idx1", 32'(seg_num[seg0 + 1]), 32'd1);
        check("run3_idx2", 32'(seg_num[seg0 + 2]), 32'd2);
        check("run3_run_cycles", 32'(run_cnt - run0), 32'd23);
        check("run3_done_pulses", 32'(done_cnt - done0), 32'd1);

        // ---------------- zero entry skipped {0,4} ----------------
        write_entry(0, 0);
        write_entry(1, 4);
        seg0 = seg_peak.size(); done0 = done_cnt; run0 = run_cnt;
        pulse_start(2);
        wait_done("skip", 100);
        tick();
        check("skip_segments", 32'(seg_peak.size() - seg0), 32'd1);
        check("skip_peak", 32'(seg_peak[seg0]), 32'd4);
        check("skip_idx", 32'(seg_num[seg0]), 32'd1);
        check("skip_run_cycles", 32'(run_cnt - run0), 32'd9);
        check("skip_done_pulses", 32'(done_cnt - done0), 32'd1);

        // ---------------- len = 0 ----------------
        done0 = done_cnt;
        pulse_start(0);
        check("empty_done", 32'(done), 32'd1);
        check("empty_busy_t1", 32'(busy), 32'd0);
        tick();
        check("empty_done_cleared", 32'(done), 32'd0);
        check("empty_busy_t2", 32'(busy), 32'd0);
        check("empty_done_pulses", 32'(done_cnt - done0), 32'd1);

        // ---------------- timeout, peak 7 with output held at 0 ----------------
        hold_zero = 1'b1;
        write_entry(0, 7);
        done0 = done_cnt; run0 = run_cnt;
        pulse_start(1);
        wait_done("tmo", 100);
        check("tmo_err_set", 32'(timeout_err), 32'd1);
        tick();
        check("tmo_busy_after", 32'(busy), 32'd0);
        check("tmo_err_sticky", 32'(timeout_err), 32'd1);
        check("tmo_run_cycles", 32'(run_cnt - run0), 32'd16);
        check("tmo_done_pulses", 32'(done_cnt - done0), 32'd1);
        hold_zero = 1'b0;
        run0 = run_cnt;
        pulse_start(1);
        check("tmo_err_cleared", 32'(timeout_err), 32'd0);
        wait_done("tmo_rerun", 100);
        check("tmo_rerun_err", 32'(timeout_err), 32'd0);
        tick();
        check("tmo_rerun_cycles", 32'(run_cnt - run0), 32'd15);

        // ---------------- abort during RUN_DOWN of entry 1 ----------------
        write_entry(0, 3);
        write_entry(1, 5);
        pulse_start(3);
        i = 0;
        while (!(seg_idx == 3'd1 && pyr_out == 4'd5) && i < 100) begin
            tick();
            i++;
        end
        check("abort_reached_peak", 32'(seg_idx == 3'd1 && pyr_out == 4'd5), 32'd1);
        tick();
        check("abort_in_run_down", 32'(pyr_rst), 32'd0);
        check("abort_falling_out", 32'(pyr_out), 32'd4);
        done0 = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pyr_rst", 32'(pyr_rst), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        tick(); tick(); tick();
        check("abort_no_done_pulse", 32'(done_cnt - done0), 32'd0);
        check("abort_still_idle", 32'(busy), 32'd0);
        // start together with abort in IDLE: start wins.
        abort = 1'b1;
        pulse_start(3);
        abort = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_seg_idx", 32'(seg_idx), 32'd0);
        tick();
        check("restart_pyr_max", 32'(pyr_max), 32'd3);
        check("restart_pyr_rst", 32'(pyr_rst), 32'd0);
        wait_done("restart", 100);
        tick();

        // ---------------- table writes while busy ----------------
        write_entry(0, 3);
        write_entry(1, 1);
        seg0 = seg_peak.size(); run0 = run_cnt;
        pulse_start(2);
        tick();
        write_entry(0, 9);
        write_entry(1, 6);
        wait_done("wr_busy", 100);
        tick();
        check("wr_busy_segments", 32'(seg_peak.size() - seg0), 32'd2);
        check("wr_busy_peak0", 32'(seg_peak[seg0]), 32'd3);
        check("wr_busy_peak1", 32'(seg_peak[seg0 + 1]), 32'd6);
        check("wr_busy_run_cycles", 32'(run_cnt - run0), 32'd20);

        // ---------------- asynchronous reset mid-sequence ----------------
        pulse_start(2);
        tick(); tick(); tick();
        check("arst_running", 32'(pyr_rst), 32'd0);
        done0 = done_cnt;
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_pyr_rst", 32'(pyr_rst), 32'd1);
        check("arst_pyr_max", 32'(pyr_max), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("arst_no_done_pulse", 32'(done_cnt - done0), 32'd0);
        // Table was cleared: entry 0 is now zero and is skipped.
        run0 = run_cnt;
        pulse_start(1);
        wait_done("arst_table", 20);
        tick();
        check("arst_table_cleared", 32'(run_cnt - run0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_piramide_seq
